dcs_sparse_attn_core: RTL and testbench
=======================================

Name: dcs_sparse_attn_core

Overview:
- Parametrised successor of the fixed 8x16 DCS attention-sparsity core.
- Streams in an N x D unsigned token matrix I and computes the Gram matrix S = I·I^T.
- Optionally applies a per-row mean threshold to S to give S'. It then streams in an N-element weight vector w and emits y = S'·w.
- New versus the previous generation: generic N/D/widths, a threshold bypass mode, i_ready/o_ready back-pressure, and output saturation.

Parameters:
- N, 8, tokens (rows of I, length of w and y). Power of two, 2..32.
- D, 16, feature dimension (columns of I), 1..64.
- DW, 8, input element width (unsigned).
- OW, 32, output word width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- i_valid  in  1  I element beat valid
- i_data  in  DW  I element; row-major, r=0..N-1, c=0..D-1
- i_ready  out  1  core accepts I beats
- thr_en  in  1  threshold enable; sampled on first I beat of a job
- w_valid  in  1  weight beat valid
- w_data  in  DW  weight element w[k], k=0..N-1
- w_ready  out  1  core accepts weight beats
- o_valid  out  1  output word valid
- o_data  out  OW  y[i], i=0..N-1, in index order
- o_ready  in  1  downstream accepts output word

Behaviour:
- Reset: one clock and a synchronous active-low reset, rst_n sampled on clk rising edge.
  - All state is cleared: matrices, counters, accumulators, sampled thr_en.
  - i_ready=0, w_ready=0, o_valid=0, o_data=0.
  - State becomes IDLE. Reset mid-job aborts the job with no partial output.
  - i_ready rises in the cycle after rst_n deasserts.
- Widths:
  - SW = 2*DW + clog2(D), width of S entries.
  - AW = SW + DW + clog2(N), width of the y accumulators.
  - All arithmetic is unsigned and lossless internally.
  - o_data = y[i] when y[i] < 2^OW, else all ones (saturate). No saturation at defaults (AW=31).
- States: IDLE, LOAD, GRAM, MEAN, CMP, WLOAD, OUT.
- IDLE:
  - i_ready=1.
  - The first accepted beat (i_valid & i_ready) stores I[0][0], latches thr_en, and moves to LOAD.
- LOAD:
  - i_ready=1. Each accepted beat is stored at the (r,c) counter position, then c++; at c=D-1, c wraps to 0 and r++.
  - Idle cycles with i_valid=0 are allowed, with no timeout.
  - After beat N*D is accepted, i_ready drops the next cycle and state becomes GRAM.
- GRAM:
  - N*N cycles; one S[i][j] per cycle, i-major order, as a D-term dot product.
- MEAN:
  - N cycles; m[i] = floor(sum_j S[i][j] / N), implemented as a shift.
- CMP:
  - N cycles; row i: S'[i][j] = S[i][j] if S[i][j] >= m[i], else 0.
  - If the latched thr_en=0, S'=S but the N cycles are still spent, so latency is mode-independent.
- WLOAD:
  - w_ready rises exactly N*N+2N+1 clock edges after the edge that accepted the last I beat.
  - Each accepted beat k does y[i] += S'[i][k] for all i in parallel (N multipliers).
  - w_ready falls in the cycle after beat N-1 is accepted; the core then goes to OUT.
  - w_valid while w_ready=0 is ignored. i_valid outside IDLE/LOAD is ignored, and i_ready=0 there.
- OUT:
  - o_valid=1 with o_data = sat(y[idx]), idx starting at 0.
  - idx advances on o_valid & o_ready.
  - With o_ready=0, o_valid and o_data hold stable.
  - After y[N-1] handshakes: o_valid=0 next cycle, all storage cleared, state IDLE, i_ready=1 the same cycle.
- Back-to-back jobs: a new I beat may be accepted in the first IDLE cycle.

Test Plan:
- Defaults; I all 1, thr_en=1, w all 1 -> S all 16, m=16, all entries kept; y[i]=128 for i=0..7; w_ready at edge N*N+2N+1=81 after last I beat.
- Defaults; row r of I all equal r+1, thr_en=1, w all 1 -> S[i][j]=16(i+1)(j+1), m[i]=72(i+1), only columns j>=4 kept; y[i]=416(i+1), i.e. 416, 832, ... 3328.
- Same stimulus with thr_en=0 -> y[i]=576(i+1); w_ready latency unchanged.
- Defaults; I and w all 255 -> y[i]=2122416000 each. Rerun with OW=24 -> every o_data = 0xFFFFFF (saturated).
- Back-pressure and gaps:
  - i_valid gaps of 1-5 cycles during LOAD and w_valid gaps during WLOAD, with results identical to gap-free.
  - o_ready low 3 cycles at idx=3 -> o_data holds y[3], no word lost or duplicated.
  - Spurious w_valid during GRAM has no effect.
- Reset: assert rst_n=0 during GRAM, then during OUT at idx=2 -> the next clock edge gives o_valid=0, w_ready=0, o_data=0; a subsequent full job gives correct results with no residue from the aborted one.

Source files
------------

// File: rtl/dcs_sparse_attn_core.sv
// dcs_sparse_attn_core: streams an N x D token matrix, forms S = I*I^T, optionally
// keeps only entries at or above their row mean, then emits y = S'*w with saturation.
module dcs_sparse_attn_core #(
    parameter int N  = 8,
    parameter int D  = 16,
    parameter int DW = 8,
    parameter int OW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          i_ready,
    input  logic          thr_en,
    input  logic          w_valid,
    input  logic [DW-1:0] w_data,
    output logic          w_ready,
    output logic          o_valid,
    output logic [OW-1:0] o_data,
    input  logic          o_ready
);
    localparam int NB = $clog2(N);
    localparam int CB = (D > 1) ? $clog2(D) : 1;
    localparam int SW = 2*DW + $clog2(D);
    localparam int AW = SW + DW + $clog2(N);
    localparam int RW = SW + NB;
    localparam int MW = (AW > OW) ? AW : OW;

    typedef enum logic [2:0] {IDLE, LOAD, GRAM, MEAN, CMP, WLOAD, OUT} state_t;

    state_t        state_q, state_d;
    logic [NB-1:0] r_q, r_d, k_q, k_d;
    logic [CB-1:0] c_q, c_d;
    logic          wrdy_q, wrdy_d;
    logic          run_q, thr_q;
    logic [DW-1:0] im_q [N][D];
    logic [SW-1:0] s_q [N][N];
    logic [SW-1:0] m_q [N];
    logic [AW-1:0] y_q [N];
    logic [SW-1:0] dot;
    logic [RW-1:0] rsum;
    logic [MW-1:0] yw;
    logic          i_hs, w_hs, o_hs, r_last, c_last, k_last, clr;

    // run_q keeps i_ready low while reset is held and for the reset edge itself
    assign i_ready = run_q && (state_q == IDLE || state_q == LOAD);
    assign w_ready = wrdy_q;
    assign o_valid = state_q == OUT;
    assign i_hs    = i_valid && i_ready;
    assign w_hs    = w_valid && w_ready;
    assign o_hs    = o_valid && o_ready;
    assign r_last  = r_q == NB'(N-1);
    assign c_last  = c_q == CB'(D-1);
    assign k_last  = k_q == NB'(N-1);
    assign yw      = MW'(y_q[r_q]);
    assign o_data  = !o_valid ? '0 : (yw > MW'({OW{1'b1}})) ? '1 : OW'(yw);

    always_comb begin
        dot = '0;
        for (int c = 0; c < D; c++) dot += SW'(im_q[r_q][c]) * SW'(im_q[k_q][c]);
        rsum = '0;
        for (int j = 0; j < N; j++) rsum += RW'(s_q[r_q][j]);
    end

    // Counters wrap naturally to zero at the end of each phase since N is a power of two
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        k_d     = k_q;
        wrdy_d  = wrdy_q;
        clr     = 1'b0;
        case (state_q)
            IDLE, LOAD: if (i_hs) begin
                c_d     = c_last ? '0 : c_q + CB'(1);
                r_d     = c_last ? r_q + NB'(1) : r_q;
                state_d = (r_last && c_last) ? GRAM : LOAD;
            end
            GRAM: begin
                k_d     = k_q + NB'(1);
                r_d     = k_last ? r_q + NB'(1) : r_q;
                state_d = (k_last && r_last) ? MEAN : GRAM;
            end
            MEAN: begin
                r_d     = r_q + NB'(1);
                state_d = r_last ? CMP : MEAN;
            end
            CMP: begin
                r_d     = r_q + NB'(1);
                state_d = r_last ? WLOAD : CMP;
            end
            WLOAD: begin
                wrdy_d = 1'b1;
                if (w_hs) begin
                    r_d     = r_q + NB'(1);
                    wrdy_d  = !r_last;
                    state_d = r_last ? OUT : WLOAD;
                end
            end
            OUT: if (o_hs) begin
                r_d     = r_q + NB'(1);
                state_d = r_last ? IDLE : OUT;
                clr     = r_last;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        run_q <= rst_n;
        if (!rst_n || clr) begin
            state_q <= IDLE;
            r_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
            wrdy_q  <= 1'b0;
            thr_q   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                m_q[i] <= '0;
                y_q[i] <= '0;
                for (int c = 0; c < D; c++) im_q[i][c] <= '0;
                for (int j = 0; j < N; j++) s_q[i][j] <= '0;
            end
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            k_q     <= k_d;
            wrdy_q  <= wrdy_d;
            if (i_hs) im_q[r_q][c_q] <= i_data;
            if (i_hs && state_q == IDLE) thr_q <= thr_en;
            if (state_q == GRAM) s_q[r_q][k_q] <= dot;
            if (state_q == MEAN) m_q[r_q] <= SW'(rsum >> NB);
            if (state_q == CMP)
                for (int j = 0; j < N; j++)
                    if (thr_q && s_q[r_q][j] < m_q[r_q]) s_q[r_q][j] <= '0;
            if (w_hs)
                for (int i = 0; i < N; i++) y_q[i] <= y_q[i] + AW'(s_q[i][r_q]) * AW'(w_data);
        end
    end
endmodule

// File: tb/tb_dcs_sparse_attn_core.sv
// tb_dcs_sparse_attn_core: random and directed jobs checked against a plain-arithmetic
// model of S = I*I^T, row-mean thresholding and y = S'*w, on a 32-bit and a 24-bit instance.
module tb_dcs_sparse_attn_core;
    localparam int N  = 8;
    localparam int D  = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_valid = 1'b0, thr_en = 1'b0, w_valid = 1'b0, o_ready = 1'b1;
    logic [DW-1:0] i_data = '0, w_data = '0;
    logic          i_ready, w_ready, o_valid;
    logic          i_ready_s, w_ready_s, o_valid_s;
    logic [31:0]   o_data;
    logic [23:0]   o_data_s;

    int          errs = 0, checks = 0;
    int unsigned im [N][D];
    int unsigned wv [N];
    longint      yexp [N];

    always #5 clk = ~clk;

    dcs_sparse_attn_core #(.N(N), .D(D), .DW(DW), .OW(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .i_ready(i_ready),
        .thr_en(thr_en), .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .o_valid(o_valid), .o_data(o_data), .o_ready(o_ready)
    );

    dcs_sparse_attn_core #(.N(N), .D(D), .DW(DW), .OW(24)) u_sat (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .i_ready(i_ready_s),
        .thr_en(thr_en), .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready_s),
        .o_valid(o_valid_s), .o_data(o_data_s), .o_ready(o_ready)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill(input int ip, input int wp);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < D; c++)
                im[r][c] = ip == 0 ? 1 : ip == 1 ? r + 1 : ip == 2 ? 255 : $urandom_range(0, 255);
            wv[r] = wp == 0 ? 1 : wp == 2 ? 255 : $urandom_range(0, 255);
        end
    endtask

    task automatic model(input bit thr);
        longint s [N][N];
        longint m, acc;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s[i][j] = 0;
                for (int c = 0; c < D; c++) s[i][j] += longint'(im[i][c]) * im[j][c];
            end
        for (int i = 0; i < N; i++) begin
            m = 0;
            for (int j = 0; j < N; j++) m += s[i][j];
            m = m / N;
            acc = 0;
            for (int k = 0; k < N; k++) acc += ((!thr || s[i][k] >= m) ? s[i][k] : 0) * wv[k];
            yexp[i] = acc;
        end
    endtask

    function automatic logic [63:0] sat24(input longint v);
        return (v >= 64'd16777216) ? 64'hFFFFFF : v;
    endfunction

    task automatic do_reset();
        i_valid = 1'b0;
        w_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_o_valid", o_valid, 0);
        chk("rst_w_ready", w_ready, 0);
        chk("rst_o_data", o_data, 0);
        chk("rst_i_ready", i_ready, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_i_ready_rise", i_ready, 1);
    endtask

    // abort: -1 runs to completion, 0 resets during GRAM, k>0 resets in OUT at index k
    task automatic run_job(input bit thr, input int igap, input int wgap, input bit stall, input int abort);
        int t, cnt;
        model(thr);
        thr_en = thr;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < D; c++) begin
                if (igap > 0) repeat ($urandom_range(0, igap)) begin @(posedge clk); #1; end
                i_valid = 1'b1;
                i_data = DW'(im[r][c]);
                t = 0;
                while (!i_ready && t < 200) begin @(posedge clk); #1; t++; end
                if (!i_ready) chk("i_ready_wait", i_ready, 1);
                @(posedge clk); #1;
                i_valid = 1'b0;
                if (r == 0 && c == 0) thr_en = ~thr;
            end
        chk("i_ready_drop", i_ready, 0);
        if (abort == 0) begin
            repeat (30) @(posedge clk);
            #1;
            do_reset();
            return;
        end
        cnt = 0;
        while (!w_ready && cnt < 200) begin
            w_valid = cnt < 20;
            w_data = DW'($urandom);
            i_valid = cnt < 20;
            i_data = DW'($urandom);
            @(posedge clk); #1;
            cnt++;
        end
        w_valid = 1'b0;
        i_valid = 1'b0;
        chk("w_latency", cnt, N*N + 2*N + 1);
        for (int k = 0; k < N; k++) begin
            if (wgap > 0) repeat ($urandom_range(0, wgap)) begin @(posedge clk); #1; end
            w_valid = 1'b1;
            w_data = DW'(wv[k]);
            t = 0;
            while (!w_ready && t < 200) begin @(posedge clk); #1; t++; end
            if (!w_ready) chk("w_ready_wait", w_ready, 1);
            @(posedge clk); #1;
            w_valid = 1'b0;
        end
        chk("w_ready_drop", w_ready, 0);
        for (int i = 0; i < N; i++) begin
            t = 0;
            while (!o_valid && t < 100) begin @(posedge clk); #1; t++; end
            chk("o_valid", o_valid, 1);
            if (i == abort) begin
                do_reset();
                return;
            end
            if (stall && i == 3) begin
                o_ready = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    chk("hold_valid", o_valid, 1);
                    chk("hold_data", o_data, yexp[3]);
                end
                o_ready = 1'b1;
            end
            chk("y", o_data, yexp[i]);
            chk("y_sat24", o_data_s, sat24(yexp[i]));
            @(posedge clk); #1;
        end
        chk("o_valid_end", o_valid, 0);
        chk("i_ready_end", i_ready, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_i_ready", i_ready, 0);
        chk("reset_w_ready", w_ready, 0);
        chk("reset_o_valid", o_valid, 0);
        chk("reset_o_data", o_data, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_i_ready_rise", i_ready, 1);
        fill(0, 0); run_job(1'b1, 0, 0, 1'b0, -1);
        fill(1, 0); run_job(1'b1, 0, 0, 1'b0, -1);
        run_job(1'b0, 0, 0, 1'b0, -1);
        fill(2, 2); run_job(1'b1, 0, 0, 1'b0, -1);
        fill(1, 0); run_job(1'b1, 5, 4, 1'b1, -1);
        fill(3, 3); run_job(1'b1, 0, 0, 1'b0, 0);
        fill(3, 3); run_job(1'b1, 0, 0, 1'b0, 2);
        fill(1, 0); run_job(1'b1, 0, 0, 1'b0, -1);
        repeat (6) begin
            fill(3, 3);
            run_job(1'($urandom_range(0, 1)), 3, 3, 1'($urandom_range(0, 1)), -1);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
